// File: rtl/gradient_image_pkg.sv
// Shared SIFT pipeline definitions: stage FSM encoding and source BRAM timing.
// Imported by the gradient, orientation and histogram stages.
package gradient_image_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } grad_state_e;

    // Source BRAM returns data two cycles after the address is presented.
    localparam int BRAM_RD_LAT    = 2;
    localparam int NUM_NEIGHBOURS = 4;
    localparam int FETCH_CYCLES   = NUM_NEIGHBOURS + BRAM_RD_LAT;

endpackage

// File: rtl/gradient_image_if.sv
// Gradient stage bus: source BRAM read port, x/y gradient BRAM write ports, control.
// master = image controller / BRAM side, slave = gradient_image.
interface gradient_image_if #(
    parameter int WIDTH     = 4,
    parameter int HEIGHT    = 4,
    parameter int BIT_DEPTH = 8
);
    localparam int AW = $clog2(WIDTH * HEIGHT);

    logic                        start;
    logic [AW-1:0]               pixel_read_addr;
    logic [BIT_DEPTH-1:0]        pixel_in;
    logic [AW-1:0]               x_write_addr;
    logic [AW-1:0]               y_write_addr;
    logic                        x_write_valid;
    logic                        y_write_valid;
    logic signed [BIT_DEPTH-1:0] x_pixel_out;
    logic signed [BIT_DEPTH-1:0] y_pixel_out;
    logic                        busy;
    logic                        done;

    modport master (
        output start, pixel_in,
        input  pixel_read_addr, x_write_addr, y_write_addr,
        input  x_write_valid, y_write_valid, x_pixel_out, y_pixel_out,
        input  busy, done
    );

    modport slave (
        input  start, pixel_in,
        output pixel_read_addr, x_write_addr, y_write_addr,
        output x_write_valid, y_write_valid, x_pixel_out, y_pixel_out,
        output busy, done
    );

endinterface

// File: rtl/gradient_image_grad_diff.sv
// Signed central difference: (a - b) at BIT_DEPTH+1 bits, arithmetic halve,
// truncate back to BIT_DEPTH. Halving keeps 8-bit inputs inside -128..127.
module grad_diff #(
    parameter int BIT_DEPTH = 8
) (
    input  logic [BIT_DEPTH-1:0]        a_i,
    input  logic [BIT_DEPTH-1:0]        b_i,
    output logic signed [BIT_DEPTH-1:0] g_o
);
    logic signed [BIT_DEPTH:0] diff;

    assign diff = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
    assign g_o  = BIT_DEPTH'(diff >>> 1);

endmodule

// File: rtl/gradient_image.sv
// Image gradient stage: per pixel, fetch clamped L/R/U/D neighbours from the
// source BRAM, then write Gx=(R-L)/2 and Gy=(D-U)/2 at the pixel's address.
module gradient_image
    import gradient_image_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int HEIGHT    = 4,
    parameter int BIT_DEPTH = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    gradient_image_if.slave bus
);
    localparam int              AW        = $clog2(WIDTH * HEIGHT);
    localparam logic [AW-1:0]   X_LAST    = AW'(WIDTH - 1);
    localparam logic [AW-1:0]   Y_LAST    = AW'(HEIGHT - 1);
    localparam logic [2:0]      CAP_FIRST = 3'(BRAM_RD_LAT);
    localparam logic [2:0]      K_LAST    = 3'(FETCH_CYCLES - 1);

    grad_state_e                 state_q;
    logic [2:0]                  k_q;
    logic [AW-1:0]               x_q, y_q;
    logic [AW-1:0]               nx, ny;
    logic                        last_px;
    logic [2:0]                  tap;
    logic [AW-1:0]               raddr_q, waddr_q;
    logic [BIT_DEPTH-1:0]        l_q, r_q, u_q;
    logic signed [BIT_DEPTH-1:0] gx, gy, gx_q, gy_q;
    logic                        wvld_q, busy_q, done_q;

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] px, input logic [AW-1:0] py);
        return AW'(int'(py) * WIDTH + int'(px));
    endfunction

    // k: 0=left 1=right 2=up 3=down, clamped to the image edge
    function automatic logic [AW-1:0] nbr_addr(input logic [AW-1:0] px, input logic [AW-1:0] py,
                                               input logic [1:0] k);
        logic [AW-1:0] cx, cy;
        cx = px;
        cy = py;
        case (k)
            2'd0:    cx = (px == '0)     ? px : px - 1'b1;
            2'd1:    cx = (px == X_LAST) ? px : px + 1'b1;
            2'd2:    cy = (py == '0)     ? py : py - 1'b1;
            default: cy = (py == Y_LAST) ? py : py + 1'b1;
        endcase
        return pix_addr(cx, cy);
    endfunction

    always_comb begin
        last_px = (x_q == X_LAST) && (y_q == Y_LAST);
        tap     = k_q - CAP_FIRST;
        if (x_q == X_LAST) begin
            nx = '0;
            ny = y_q + 1'b1;
        end else begin
            nx = x_q + 1'b1;
            ny = y_q;
        end
    end

    // D is never registered: it arrives on the last fetch cycle and feeds Gy directly.
    grad_diff #(.BIT_DEPTH(BIT_DEPTH)) u_gx (.a_i(r_q),          .b_i(l_q), .g_o(gx));
    grad_diff #(.BIT_DEPTH(BIT_DEPTH)) u_gy (.a_i(bus.pixel_in), .b_i(u_q), .g_o(gy));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            l_q     <= '0;
            r_q     <= '0;
            u_q     <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            wvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wvld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // a start coinciding with done is dropped
                    if (bus.start && !done_q) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        raddr_q <= '0;
                    end
                end
                ST_FETCH: begin
                    k_q <= k_q + 3'd1;
                    if (k_q < 3'd3)
                        raddr_q <= nbr_addr(x_q, y_q, k_q[1:0] + 2'd1);
                    if (k_q >= CAP_FIRST) begin
                        case (tap)
                            3'd0:    l_q <= bus.pixel_in;
                            3'd1:    r_q <= bus.pixel_in;
                            3'd2:    u_q <= bus.pixel_in;
                            default: ;
                        endcase
                    end
                    if (k_q == K_LAST) begin
                        state_q <= ST_WRITE;
                        waddr_q <= pix_addr(x_q, y_q);
                        wvld_q  <= 1'b1;
                        gx_q    <= gx;
                        gy_q    <= gy;
                    end
                end
                ST_WRITE: begin
                    if (last_px) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                        x_q     <= nx;
                        y_q     <= ny;
                        k_q     <= '0;
                        raddr_q <= nbr_addr(nx, ny, 2'd0);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.pixel_read_addr = raddr_q;
    assign bus.x_write_addr    = waddr_q;
    assign bus.y_write_addr    = waddr_q;
    assign bus.x_write_valid   = wvld_q;
    assign bus.y_write_valid   = wvld_q;
    assign bus.x_pixel_out     = gx_q;
    assign bus.y_pixel_out     = gy_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_gradient_image.sv
// Self-checking bench for gradient_image: BRAM model, write monitor and a
// plain-arithmetic gradient reference over directed and random images.
module tb_gradient_image;
    localparam int W = 4, H = 4, BD = 8, N = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0, checks = 0;

    gradient_image_if #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD)) bus ();

    gradient_image #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // source BRAM, two-cycle read latency
    int unsigned   img [N];
    logic [BD-1:0] rd_d1;
    always @(posedge clk) begin
        rd_d1        <= BD'(img[bus.pixel_read_addr]);
        bus.pixel_in <= rd_d1;
    end

    // write / done / busy monitor plus destination BRAMs
    int wr_cyc[$], wr_addr[$], wr_yaddr[$], wr_gx[$], wr_gy[$], wr_yv[$];
    int done_cyc[$], done_busy[$];
    int busy_cnt;
    int gx_mem [N], gy_mem [N];
    always @(negedge clk) begin
        if (bus.x_write_valid) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(bus.x_write_addr));
            wr_yaddr.push_back(int'(bus.y_write_addr));
            wr_gx.push_back(int'(bus.x_pixel_out));
            wr_gy.push_back(int'(bus.y_pixel_out));
            wr_yv.push_back(int'(bus.y_write_valid));
            gx_mem[bus.x_write_addr] = int'(bus.x_pixel_out);
            gy_mem[bus.y_write_addr] = int'(bus.y_pixel_out);
        end
        if (bus.done) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(int'(bus.busy));
        end
        if (bus.busy) busy_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic int px(input int x, input int y);
        int cx, cy;
        cx = (x < 0) ? 0 : (x > W - 1) ? W - 1 : x;
        cy = (y < 0) ? 0 : (y > H - 1) ? H - 1 : y;
        return int'(img[cy * W + cx]);
    endfunction

    // floor((hi - lo) / 2), wrapped to BD-bit two's complement
    function automatic int half_diff(input int hi, input int lo);
        int d;
        d = hi - lo;
        d = (d >= 0) ? d / 2 : -((-d + 1) / 2);
        d = d & ((1 << BD) - 1);
        if (d >= (1 << (BD - 1))) d -= (1 << BD);
        return d;
    endfunction

    function automatic int exp_gx(input int p);
        return half_diff(px(p % W + 1, p / W), px(p % W - 1, p / W));
    endfunction

    function automatic int exp_gy(input int p);
        return half_diff(px(p % W, p / W + 1), px(p % W, p / W - 1));
    endfunction

    // 0 const 100, 1 x-ramp 16x, 2 columns 0/255/0/0, 3 y-ramp 20y, else random
    task automatic fill(input int mode);
        int col [4];
        col = '{0, 255, 0, 0};
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       img[i] = 100;
                1:       img[i] = 16 * (i % W);
                2:       img[i] = col[i % W];
                3:       img[i] = 20 * (i / W);
                default: img[i] = $urandom_range(0, 255);
            endcase
        end
    endtask

    task automatic clear_mon;
        wr_cyc.delete(); wr_addr.delete(); wr_yaddr.delete();
        wr_gx.delete(); wr_gy.delete(); wr_yv.delete();
        done_cyc.delete(); done_busy.delete();
        busy_cnt = 0;
    endtask

    // full run; restart_at>0 pulses start mid-run, at_done pulses start on done
    task automatic run_img(input string nm, input int restart_at, input bit at_done);
        int s, t, bc;
        clear_mon();
        tick();
        bus.start = 1'b1;
        s = cyc;
        tick();
        bus.start = 1'b0;
        t = 0;
        while (done_cyc.size() == 0 && t < 300) begin
            bus.start = (restart_at > 0 && cyc == s + restart_at);
            tick();
            t++;
        end
        bus.start = 1'b0;
        bc = busy_cnt;
        if (at_done) begin
            bus.start = 1'b1;
            tick();
            chk({nm, "_start_on_done_ignored"}, int'(bus.busy), 0);
            tick();
            bus.start = 1'b0;
            chk({nm, "_start_after_done"}, int'(bus.busy), 1);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end else begin
            repeat (5) tick();
            chk({nm, "_hold_gx"}, int'(bus.x_pixel_out), exp_gx(N - 1));
            chk({nm, "_hold_gy"}, int'(bus.y_pixel_out), exp_gy(N - 1));
            chk({nm, "_idle_valid"}, int'(bus.x_write_valid), 0);
        end
        chk({nm, "_nwrites"}, wr_cyc.size(), N);
        chk({nm, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) begin
            chk({nm, "_done_cyc"}, done_cyc[0] - s, 7 * N + 1);
            chk({nm, "_busy_at_done"}, done_busy[0], 0);
        end
        chk({nm, "_busy_cycles"}, bc, 7 * N);
        for (int i = 0; i < N && i < wr_cyc.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), wr_addr[i], i);
            chk($sformatf("%s_yaddr%0d", nm, i), wr_yaddr[i], wr_addr[i]);
            chk($sformatf("%s_yvld%0d", nm, i), wr_yv[i], 1);
            chk($sformatf("%s_wcyc%0d", nm, i), wr_cyc[i] - s, 7 * (i + 1));
            chk($sformatf("%s_gx%0d", nm, i), wr_gx[i], exp_gx(i));
            chk($sformatf("%s_gy%0d", nm, i), wr_gy[i], exp_gy(i));
        end
    endtask

    task automatic abort_run;
        int s, n0;
        fill(9);
        clear_mon();
        tick();
        bus.start = 1'b1;
        s = cyc;
        tick();
        bus.start = 1'b0;
        while (cyc < s + 40) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_xvld", int'(bus.x_write_valid), 0);
        chk("rst_yvld", int'(bus.y_write_valid), 0);
        chk("rst_raddr", int'(bus.pixel_read_addr), 0);
        chk("rst_waddr", int'(bus.x_write_addr) + int'(bus.y_write_addr), 0);
        chk("rst_gx", int'(bus.x_pixel_out), 0);
        chk("rst_gy", int'(bus.y_pixel_out), 0);
        n0 = wr_cyc.size();
        chk("abort_writes_before", n0, 5);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (150) tick();
        chk("abort_no_writes_after", wr_cyc.size(), n0);
        chk("abort_no_done", done_cyc.size(), 0);
        chk("abort_idle", int'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) img[i] = 0;
        tick();
        chk("init_busy", int'(bus.busy), 0);
        chk("init_done", int'(bus.done), 0);
        chk("init_vld", int'(bus.x_write_valid) + int'(bus.y_write_valid), 0);
        chk("init_addr", int'(bus.pixel_read_addr) + int'(bus.x_write_addr), 0);
        chk("init_data", int'(bus.x_pixel_out) | int'(bus.y_pixel_out), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        fill(0); run_img("const", 0, 1'b0);
        fill(1); run_img("hramp", 0, 1'b0);
        fill(2); run_img("cols", 0, 1'b0);
        fill(3); run_img("vramp", 0, 1'b0);
        fill(0); run_img("restart", 50, 1'b0);
        for (int r = 0; r < 4; r++) begin
            fill(9);
            repeat ($urandom_range(0, 6)) tick();
            run_img($sformatf("rand%0d", r), 0, 1'b0);
        end
        fill(9); run_img("donestart", 0, 1'b1);

        abort_run();
        for (int i = 0; i < N; i++) begin
            gx_mem[i] = 99;
            gy_mem[i] = 99;
        end
        fill(0); run_img("after_rst", 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("mem_gx%0d", i), gx_mem[i], 0);
            chk($sformatf("mem_gy%0d", i), gy_mem[i], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
